regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Dual-read-port register file with per-register busy (pending writeback) bits,
// write-through bypass on reads, and a hard-wired zero register.
module regfile_mp #(
    parameter int unsigned          REG_SZ  = 64,
    parameter int unsigned          REG_NUM = 32,
    parameter int unsigned          SP_IDX  = 2,
    parameter logic [REG_SZ-1:0]    SP_INIT = REG_SZ'(64'h0000_0000_0001_0000),
    localparam int unsigned         AW      = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ra_en,
    input  logic [AW-1:0]     ra_idx,
    output logic [REG_SZ-1:0] ra_data,
    output logic              ra_vld,
    output logic              ra_busy,
    input  logic              rb_en,
    input  logic [AW-1:0]     rb_idx,
    output logic [REG_SZ-1:0] rb_data,
    output logic              rb_vld,
    output logic              rb_busy,
    input  logic              w_en,
    input  logic [AW-1:0]     w_idx,
    input  logic [REG_SZ-1:0] w_data,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_idx
);

    logic [REG_SZ-1:0]  regs [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_nxt;
    logic [REG_SZ-1:0]  ra_nxt;
    logic [REG_SZ-1:0]  rb_nxt;

    // Busy update: write clears, reserve sets afterwards so a same-edge reserve wins.
    always_comb begin
        busy_nxt = busy;
        if (w_en) begin
            busy_nxt[w_idx] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;

        ra_nxt = regs[ra_idx];
        if (w_en && (w_idx == ra_idx)) begin
            ra_nxt = w_data;
        end
        if (ra_idx == '0) begin
            ra_nxt = '0;
        end

        rb_nxt = regs[rb_idx];
        if (w_en && (w_idx == rb_idx)) begin
            rb_nxt = w_data;
        end
        if (rb_idx == '0) begin
            rb_nxt = '0;
        end
    end

    // Read outputs (data and busy) hold their last value while the port is idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
            end
            busy    <= '0;
            ra_data <= '0;
            ra_vld  <= 1'b0;
            ra_busy <= 1'b0;
            rb_data <= '0;
            rb_vld  <= 1'b0;
            rb_busy <= 1'b0;
        end else begin
            if (w_en && (w_idx != '0)) begin
                regs[w_idx] <= w_data;
            end
            busy   <= busy_nxt;
            ra_vld <= ra_en;
            rb_vld <= rb_en;
            if (ra_en) begin
                ra_data <= ra_nxt;
                ra_busy <= busy_nxt[ra_idx];
            end
            if (rb_en) begin
                rb_data <= rb_nxt;
                rb_busy <= busy_nxt[rb_idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios and random traffic on a
// default instance, plus random traffic on a 16 x 32-bit instance.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ra_en, rb_en, w_en, rsv_en;
    logic [4:0]  ra_idx, rb_idx, w_idx, rsv_idx;
    logic [63:0] w_data, ra_data, rb_data;
    logic        ra_vld, rb_vld, ra_busy, rb_busy;

    logic        s_rst;
    logic        s_ra_en, s_rb_en, s_w_en, s_rsv_en;
    logic [3:0]  s_ra_idx, s_rb_idx, s_w_idx, s_rsv_idx;
    logic [31:0] s_w_data, s_ra_data, s_rb_data;
    logic        s_ra_vld, s_rb_vld, s_ra_busy, s_rb_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model and scoreboard for the default instance
    logic [63:0] m_reg [32];
    logic        m_busy [32];
    logic [64:0] qa [$];
    logic [64:0] qb [$];
    logic        exp_va, exp_vb;
    logic [63:0] la, lb;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst),
        .ra_en(ra_en), .ra_idx(ra_idx), .ra_data(ra_data), .ra_vld(ra_vld), .ra_busy(ra_busy),
        .rb_en(rb_en), .rb_idx(rb_idx), .rb_data(rb_data), .rb_vld(rb_vld), .rb_busy(rb_busy),
        .w_en(w_en), .w_idx(w_idx), .w_data(w_data),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx)
    );

    regfile_mp #(.REG_SZ(32), .REG_NUM(16), .SP_INIT(32'h0001_0000)) u_dut_s (
        .clk(clk), .rst(s_rst),
        .ra_en(s_ra_en), .ra_idx(s_ra_idx), .ra_data(s_ra_data), .ra_vld(s_ra_vld), .ra_busy(s_ra_busy),
        .rb_en(s_rb_en), .rb_idx(s_rb_idx), .rb_data(s_rb_data), .rb_vld(s_rb_vld), .rb_busy(s_rb_busy),
        .w_en(s_w_en), .w_idx(s_w_idx), .w_data(s_w_data),
        .rsv_en(s_rsv_en), .rsv_idx(s_rsv_idx)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = (i == 2) ? 64'h0000_0000_0001_0000 : 64'h0;
            m_busy[i] = 1'b0;
        end
        la = 64'h0;
        lb = 64'h0;
        exp_va = 1'b0;
        exp_vb = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    function automatic logic [63:0] rdv(input logic [4:0] idx);
        if (idx == 5'd0) return 64'h0;
        if (w_en && (w_idx == idx)) return w_data;
        return m_reg[idx];
    endfunction

    task automatic set_in(input logic ae, input logic [4:0] ai, input logic be, input logic [4:0] bi,
                          input logic we, input logic [4:0] wi, input logic [63:0] wd,
                          input logic re, input logic [4:0] ri);
        ra_en = ae; ra_idx = ai; rb_en = be; rb_idx = bi;
        w_en = we; w_idx = wi; w_data = wd; rsv_en = re; rsv_idx = ri;
    endtask

    // Push expected read results for the coming edge, advance the model, then clock.
    task automatic tick();
        logic nb [32];
        if (!rst) begin
            model_reset();
        end else begin
            nb = m_busy;
            if (w_en) nb[w_idx] = 1'b0;
            if (rsv_en) nb[rsv_idx] = 1'b1;
            nb[0] = 1'b0;
            if (ra_en) qa.push_back({nb[ra_idx], rdv(ra_idx)});
            if (rb_en) qb.push_back({nb[rb_idx], rdv(rb_idx)});
            exp_va = ra_en;
            exp_vb = rb_en;
            if (w_en && (w_idx != 5'd0)) m_reg[w_idx] = w_data;
            m_busy = nb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd9);
        tick();
        tick();
        n_cmp++;
        if (ra_vld !== 1'b0 || rb_vld !== 1'b0) begin
            n_err++; $display("FAIL reset_vld: got a=%b b=%b want 0 0", ra_vld, rb_vld);
        end
        n_cmp++;
        if (ra_data !== 64'h0 || rb_data !== 64'h0) begin
            n_err++; $display("FAIL reset_data: got a=%h b=%h want 0 0", ra_data, rb_data);
        end
        n_cmp++;
        if (ra_busy !== 1'b0 || rb_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got a=%b b=%b want 0 0", ra_busy, rb_busy);
        end
        rst = 1'b1;
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    endtask

    task automatic test_sp_read();
        logic [64:0] ea, eb;
        for (int s = 0; s < 2; s++) begin
            case (s)
                0: set_in(1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
                default: set_in(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
            endcase
            tick();
            n_cmp++;
            if (ra_vld !== exp_va || rb_vld !== exp_vb) begin
                n_err++; $display("FAIL sp_read vld step %0d: got %b%b want %b%b", s, ra_vld, rb_vld, exp_va, exp_vb);
            end
            if (exp_va) begin
                ea = qa.pop_front(); la = ea[63:0]; n_cmp++;
                if ({ra_busy, ra_data} !== ea) begin
                    n_err++; $display("FAIL sp_read port_a step %0d: got %b/%h want %b/%h", s, ra_busy, ra_data, ea[64], ea[63:0]);
                end
            end
            if (exp_vb) begin
                eb = qb.pop_front(); lb = eb[63:0]; n_cmp++;
                if ({rb_busy, rb_data} !== eb) begin
                    n_err++; $display("FAIL sp_read port_b step %0d: got %b/%h want %b/%h", s, rb_busy, rb_data, eb[64], eb[63:0]);
                end
            end else begin
                n_cmp++;
                if (rb_data !== lb) begin
                    n_err++; $display("FAIL sp_read b_hold step %0d: got %h want %h", s, rb_data, lb);
                end
            end
        end
        n_cmp++;
        if (ra_data !== 64'h0000_0000_0001_0000) begin
            n_err++; $display("FAIL sp_init_value: got %h want 10000", ra_data);
        end
    endtask

    task automatic test_bypass();
        logic [64:0] ea, eb;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: set_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0);
                1: set_in(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd8, 64'h1234_5678_9ABC_DEF0, 1'b0, 5'd0);
                default: set_in(1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
            endcase
            tick();
            n_cmp++;
            if (ra_vld !== exp_va || rb_vld !== exp_vb) begin
                n_err++; $display("FAIL bypass vld step %0d: got %b%b want %b%b", s, ra_vld, rb_vld, exp_va, exp_vb);
            end
            if (exp_va) begin
                ea = qa.pop_front(); la = ea[63:0]; n_cmp++;
                if ({ra_busy, ra_data} !== ea) begin
                    n_err++; $display("FAIL bypass port_a step %0d: got %b/%h want %b/%h", s, ra_busy, ra_data, ea[64], ea[63:0]);
                end
            end else begin
                n_cmp++;
                if (ra_data !== la) begin
                    n_err++; $display("FAIL bypass a_hold step %0d: got %h want %h", s, ra_data, la);
                end
            end
            if (exp_vb) begin
                eb = qb.pop_front(); lb = eb[63:0]; n_cmp++;
                if ({rb_busy, rb_data} !== eb) begin
                    n_err++; $display("FAIL bypass port_b step %0d: got %b/%h want %b/%h", s, rb_busy, rb_data, eb[64], eb[63:0]);
                end
            end else begin
                n_cmp++;
                if (rb_data !== lb) begin
                    n_err++; $display("FAIL bypass b_hold step %0d: got %h want %h", s, rb_data, lb);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [64:0] ea, eb;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0);
                1: set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0);
                2: set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
                default: set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 64'hABCD, 1'b1, 5'd0);
            endcase
            tick();
            n_cmp++;
            if (ra_vld !== exp_va || rb_vld !== exp_vb) begin
                n_err++; $display("FAIL zero_reg vld step %0d: got %b%b want %b%b", s, ra_vld, rb_vld, exp_va, exp_vb);
            end
            ea = qa.pop_front(); la = ea[63:0]; n_cmp++;
            if ({ra_busy, ra_data} !== ea) begin
                n_err++; $display("FAIL zero_reg port_a step %0d: got %b/%h want %b/%h", s, ra_busy, ra_data, ea[64], ea[63:0]);
            end
            eb = qb.pop_front(); lb = eb[63:0]; n_cmp++;
            if ({rb_busy, rb_data} !== eb) begin
                n_err++; $display("FAIL zero_reg port_b step %0d: got %b/%h want %b/%h", s, rb_busy, rb_data, eb[64], eb[63:0]);
            end
        end
    endtask

    task automatic test_busy();
        logic [64:0] ea, eb;
        for (int s = 0; s < 7; s++) begin
            case (s)
                0: set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
                1: set_in(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
                2: set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 64'd5, 1'b0, 5'd0);
                3: set_in(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
                4: set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 64'd6, 1'b1, 5'd9);
                5: set_in(1'b1, 5'd9, 1'b1, 5'd10, 1'b0, 5'd0, 64'h0, 1'b1, 5'd10);
                default: set_in(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd10, 64'd77, 1'b0, 5'd0);
            endcase
            tick();
            n_cmp++;
            if (ra_vld !== exp_va || rb_vld !== exp_vb) begin
                n_err++; $display("FAIL busy vld step %0d: got %b%b want %b%b", s, ra_vld, rb_vld, exp_va, exp_vb);
            end
            if (exp_va) begin
                ea = qa.pop_front(); la = ea[63:0]; n_cmp++;
                if ({ra_busy, ra_data} !== ea) begin
                    n_err++; $display("FAIL busy port_a step %0d: got %b/%h want %b/%h", s, ra_busy, ra_data, ea[64], ea[63:0]);
                end
            end else begin
                n_cmp++;
                if (ra_data !== la) begin
                    n_err++; $display("FAIL busy a_hold step %0d: got %h want %h", s, ra_data, la);
                end
            end
            if (exp_vb) begin
                eb = qb.pop_front(); lb = eb[63:0]; n_cmp++;
                if ({rb_busy, rb_data} !== eb) begin
                    n_err++; $display("FAIL busy port_b step %0d: got %b/%h want %b/%h", s, rb_busy, rb_data, eb[64], eb[63:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] ea, eb;
        for (int s = 0; s < 5; s++) begin
            rst = 1'b1;
            case (s)
                0: set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 64'd11, 1'b1, 5'd4);
                1: set_in(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
                2: begin
                    rst = 1'b0;
                    set_in(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 64'd99, 1'b1, 5'd3);
                end
                3: set_in(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
                default: set_in(1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
            endcase
            tick();
            n_cmp++;
            if (ra_vld !== exp_va || rb_vld !== exp_vb) begin
                n_err++; $display("FAIL reset_mid vld step %0d: got %b%b want %b%b", s, ra_vld, rb_vld, exp_va, exp_vb);
            end
            if (exp_va) begin
                ea = qa.pop_front(); la = ea[63:0]; n_cmp++;
                if ({ra_busy, ra_data} !== ea) begin
                    n_err++; $display("FAIL reset_mid port_a step %0d: got %b/%h want %b/%h", s, ra_busy, ra_data, ea[64], ea[63:0]);
                end
            end else begin
                n_cmp++;
                if (ra_data !== la) begin
                    n_err++; $display("FAIL reset_mid a_hold step %0d: got %h want %h", s, ra_data, la);
                end
            end
            if (exp_vb) begin
                eb = qb.pop_front(); lb = eb[63:0]; n_cmp++;
                if ({rb_busy, rb_data} !== eb) begin
                    n_err++; $display("FAIL reset_mid port_b step %0d: got %b/%h want %b/%h", s, rb_busy, rb_data, eb[64], eb[63:0]);
                end
            end else begin
                n_cmp++;
                if (rb_data !== lb) begin
                    n_err++; $display("FAIL reset_mid b_hold step %0d: got %h want %h", s, rb_data, lb);
                end
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [64:0] ea, eb;
        for (int s = 0; s < 3000; s++) begin
            rst = ($urandom_range(0, 199) != 0);
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            tick();
            n_cmp++;
            if (ra_vld !== exp_va || rb_vld !== exp_vb) begin
                n_err++; $display("FAIL random vld step %0d: got %b%b want %b%b", s, ra_vld, rb_vld, exp_va, exp_vb);
            end
            if (exp_va) begin
                ea = qa.pop_front(); la = ea[63:0]; n_cmp++;
                if ({ra_busy, ra_data} !== ea) begin
                    n_err++; $display("FAIL random port_a step %0d: got %b/%h want %b/%h", s, ra_busy, ra_data, ea[64], ea[63:0]);
                end
            end else begin
                n_cmp++;
                if (ra_data !== la) begin
                    n_err++; $display("FAIL random a_hold step %0d: got %h want %h", s, ra_data, la);
                end
            end
            if (exp_vb) begin
                eb = qb.pop_front(); lb = eb[63:0]; n_cmp++;
                if ({rb_busy, rb_data} !== eb) begin
                    n_err++; $display("FAIL random port_b step %0d: got %b/%h want %b/%h", s, rb_busy, rb_data, eb[64], eb[63:0]);
                end
            end else begin
                n_cmp++;
                if (rb_data !== lb) begin
                    n_err++; $display("FAIL random b_hold step %0d: got %h want %h", s, rb_data, lb);
                end
            end
        end
        rst = 1'b1;
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    endtask

    // Random traffic on the 16 x 32-bit instance with its own inline model.
    task automatic test_small_random();
        logic [31:0] r2 [16];
        logic        b2 [16];
        logic        nb2 [16];
        logic [32:0] sqa [$];
        logic [32:0] sqb [$];
        logic [32:0] ea, eb;
        logic [31:0] l2a, l2b, va, vb;
        logic        eva, evb;
        s_rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            r2[i] = (i == 2) ? 32'h0001_0000 : 32'h0;
            b2[i] = 1'b0;
        end
        l2a = 32'h0;
        l2b = 32'h0;
        n_cmp++;
        if (s_ra_vld !== 1'b0 || s_ra_data !== 32'h0 || s_rb_busy !== 1'b0) begin
            n_err++; $display("FAIL small_reset: got vld=%b data=%h busy=%b want 0 0 0", s_ra_vld, s_ra_data, s_rb_busy);
        end
        s_rst = 1'b1;
        for (int s = 0; s < 5000; s++) begin
            s_ra_en = 1'($urandom_range(0, 1)); s_ra_idx = 4'($urandom_range(0, 15));
            s_rb_en = 1'($urandom_range(0, 1)); s_rb_idx = 4'($urandom_range(0, 15));
            s_w_en = 1'($urandom_range(0, 1));  s_w_idx = 4'($urandom_range(0, 15)); s_w_data = $urandom;
            s_rsv_en = 1'($urandom_range(0, 1)); s_rsv_idx = 4'($urandom_range(0, 15));
            nb2 = b2;
            if (s_w_en) nb2[s_w_idx] = 1'b0;
            if (s_rsv_en) nb2[s_rsv_idx] = 1'b1;
            nb2[0] = 1'b0;
            va = (s_w_en && s_w_idx == s_ra_idx) ? s_w_data : r2[s_ra_idx];
            vb = (s_w_en && s_w_idx == s_rb_idx) ? s_w_data : r2[s_rb_idx];
            if (s_ra_idx == 4'd0) va = 32'h0;
            if (s_rb_idx == 4'd0) vb = 32'h0;
            if (s_ra_en) sqa.push_back({nb2[s_ra_idx], va});
            if (s_rb_en) sqb.push_back({nb2[s_rb_idx], vb});
            eva = s_ra_en;
            evb = s_rb_en;
            if (s_w_en && s_w_idx != 4'd0) r2[s_w_idx] = s_w_data;
            b2 = nb2;
            @(posedge clk);
            #1;
            n_cmp++;
            if (s_ra_vld !== eva || s_rb_vld !== evb) begin
                n_err++; $display("FAIL small vld step %0d: got %b%b want %b%b", s, s_ra_vld, s_rb_vld, eva, evb);
            end
            ea = eva ? sqa.pop_front() : {s_ra_busy, l2a};
            eb = evb ? sqb.pop_front() : {s_rb_busy, l2b};
            l2a = ea[31:0];
            l2b = eb[31:0];
            n_cmp++;
            if ({s_ra_busy, s_ra_data} !== ea || {s_rb_busy, s_rb_data} !== eb) begin
                n_err++; $display("FAIL small data step %0d: got a=%b/%h b=%b/%h want a=%b/%h b=%b/%h", s,
                    s_ra_busy, s_ra_data, s_rb_busy, s_rb_data, ea[32], ea[31:0], eb[32], eb[31:0]);
            end
        end
        s_ra_en = 1'b0; s_rb_en = 1'b0; s_w_en = 1'b0; s_rsv_en = 1'b0;
    endtask

    initial begin
        s_rst = 1'b0;
        s_ra_en = 1'b0; s_ra_idx = 4'd0; s_rb_en = 1'b0; s_rb_idx = 4'd0;
        s_w_en = 1'b0; s_w_idx = 4'd0; s_w_data = 32'h0; s_rsv_en = 1'b0; s_rsv_idx = 4'd0;
        rst = 1'b0;
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        model_reset();
        test_reset();
        test_sp_read();
        test_bypass();
        test_zero_reg();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        test_small_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
